// File: rtl/bram_mover_sched.sv
// bram_mover_sched: round-robin arbiter that shares a single data_mover_bram
// between NUM_REQ requesters. It launches the mover with a one-cycle run
// pulse and a saturated count, waits for the mover's done, and returns a
// one-cycle completion pulse to the granted requester.
// Optional feature macro: MOVER_TIMEOUT_EN adds a RUN-state watchdog that
// sets a sticky o_timeout flag and force-completes the job.
//
// state  | meaning
// IDLE   | no job; arbitrate when any request is up and the mover is idle
// LAUNCH | o_mv_run high for this single cycle
// RUN    | waiting for the mover's done
// DONE   | two cycles: o_job_done is raised, then grant/busy are released

module bram_mover_sched #(
    parameter int NUM_REQ     = 2,
    parameter int CNT_BIT     = 31,
    parameter int MEM_SIZE    = 4096,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*CNT_BIT-1:0] i_num_cnt,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [NUM_REQ-1:0]         o_job_done,
    output logic                       o_busy,
    output logic                       o_mv_run,
    output logic [CNT_BIT-1:0]         o_mv_num_cnt,
    input  logic                       i_mv_idle,
    input  logic                       i_mv_done,
    output logic                       o_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_BIT-1:0] CNT_MAX = CNT_BIT'(MEM_SIZE);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic [CNT_BIT-1:0] cnt_arr [NUM_REQ];
    logic [CNT_BIT-1:0] win_cnt;
    logic [CNT_BIT-1:0] sat_cnt;
    logic [PTR_W-1:0]   rr_next;

`ifdef MOVER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign o_timeout = 1'b0;
`endif

    // Unpack the per-requester count slices for indexed selection.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cnt_arr[k] = i_num_cnt[k*CNT_BIT +: CNT_BIT];
        end
    end

    // Pick the first requesting bit at or after rr_ptr, wrapping around.
    always_comb begin
        logic [PTR_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && i_req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Winner's count, clamped to the BRAM depth; pointer moves past the winner.
    always_comb begin
        win_cnt = cnt_arr[win_idx];
        sat_cnt = (win_cnt > CNT_MAX) ? CNT_MAX : win_cnt;
        rr_next = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
    end

    // Job sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            gnt_idx      <= '0;
            o_grant      <= '0;
            o_job_done   <= '0;
            o_busy       <= 1'b0;
            o_mv_run     <= 1'b0;
            o_mv_num_cnt <= '0;
`ifdef MOVER_TIMEOUT_EN
            wd_cnt       <= '0;
            o_timeout    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found && i_mv_idle) begin
                        o_grant      <= NUM_REQ'(1) << win_idx;
                        gnt_idx      <= win_idx;
                        o_mv_num_cnt <= sat_cnt;
                        o_busy       <= 1'b1;
                        // A zero-length move never touches the mover.
                        if (win_cnt == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_LAUNCH;
                            o_mv_run <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    o_mv_run <= 1'b0;
                    state    <= S_RUN;
`ifdef MOVER_TIMEOUT_EN
                    wd_cnt   <= '0;
`endif
                end
                S_RUN: begin
`ifdef MOVER_TIMEOUT_EN
                    if (i_mv_done) begin
                        state <= S_DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        o_timeout <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`else
                    if (i_mv_done) begin
                        state <= S_DONE;
                    end
`endif
                end
                default: begin
                    // First DONE cycle raises the pulse, second one releases the job.
                    if (o_job_done == '0) begin
                        o_job_done <= o_grant;
                    end else begin
                        o_job_done <= '0;
                        o_grant    <= '0;
                        o_busy     <= 1'b0;
                        rr_ptr     <= rr_next;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_mover_sched.sv
// Self-checking bench for bram_mover_sched (default build, NUM_REQ=2).
module tb_bram_mover_sched;

    localparam int CB = 31;

    logic          clk;
    logic          reset;
    logic [1:0]    i_req;
    logic [2*CB-1:0] i_num_cnt;
    logic [1:0]    o_grant;
    logic [1:0]    o_job_done;
    logic          o_busy;
    logic          o_mv_run;
    logic [CB-1:0] o_mv_num_cnt;
    logic          i_mv_idle;
    logic          i_mv_done;
    logic          o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    bram_mover_sched dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_num_cnt    (i_num_cnt),
        .o_grant      (o_grant),
        .o_job_done   (o_job_done),
        .o_busy       (o_busy),
        .o_mv_run     (o_mv_run),
        .o_mv_num_cnt (o_mv_num_cnt),
        .i_mv_idle    (i_mv_idle),
        .i_mv_done    (i_mv_done),
        .o_timeout    (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    req;
        logic [CB-1:0] c0;
        logic [CB-1:0] c1;
        logic [1:0]    eg;
        logic [CB-1:0] ec;
        bit            er;
        int            dly;
        bit            lvl;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " grant"},   64'(o_grant), 64'd0);
        chk({nm, " jobdone"}, 64'(o_job_done), 64'd0);
        chk({nm, " busy"},    64'(o_busy), 64'd0);
        chk({nm, " run"},     64'(o_mv_run), 64'd0);
        chk({nm, " cnt"},     64'(o_mv_num_cnt), 64'd0);
        chk({nm, " timeout"}, 64'(o_timeout), 64'd0);
    endtask

    // One job from an IDLE scheduler, checked against the launch/completion timing.
    task automatic run_job(input logic [1:0] req, input logic [CB-1:0] c0, input logic [CB-1:0] c1,
                           input logic [1:0] eg, input logic [CB-1:0] ec, input bit er,
                           input int dly, input bit lvl, input string nm);
        i_req     = req;
        i_num_cnt = {c1, c0};
        i_mv_idle = 1'b1;
        tick();
        chk({nm, " grant"},   64'(o_grant), 64'(eg));
        chk({nm, " busy"},    64'(o_busy), 64'd1);
        chk({nm, " run"},     64'(o_mv_run), 64'(er));
        chk({nm, " cnt"},     64'(o_mv_num_cnt), 64'(ec));
        chk({nm, " jd_early"}, 64'(o_job_done), 64'd0);
        if (er) begin
            i_mv_idle = 1'b0;
            tick();
            chk({nm, " run_fall"}, 64'(o_mv_run), 64'd0);
            chk({nm, " grant_hold"}, 64'(o_grant), 64'(eg));
            i_mv_done = 1'b0;
            for (int i = 0; i < dly; i++) begin
                tick();
                chk({nm, " jd_wait"}, 64'(o_job_done), 64'd0);
                chk({nm, " cnt_hold"}, 64'(o_mv_num_cnt), 64'(ec));
            end
            i_mv_done = 1'b1;
            tick();
            chk({nm, " jd_lat"}, 64'(o_job_done), 64'd0);
            chk({nm, " busy_run"}, 64'(o_busy), 64'd1);
            if (!lvl) i_mv_done = 1'b0;
            i_mv_idle = 1'b1;
            tick();
        end else begin
            tick();
        end
        chk({nm, " jobdone"},   64'(o_job_done), 64'(eg));
        chk({nm, " grant_dn"},  64'(o_grant), 64'(eg));
        chk({nm, " busy_dn"},   64'(o_busy), 64'd1);
        chk({nm, " run_dn"},    64'(o_mv_run), 64'd0);
        tick();
        chk({nm, " jd_clr"},    64'(o_job_done), 64'd0);
        chk({nm, " grant_clr"}, 64'(o_grant), 64'd0);
        chk({nm, " busy_clr"},  64'(o_busy), 64'd0);
    endtask

    function automatic logic [CB-1:0] rnd_cnt();
        logic [CB-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = 31'd1;
            2: v = 31'd4096;
            3: v = 31'd4097;
            4: v = CB'($urandom_range(2, 4095));
            default: v = CB'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int            rr;
        int            win;
        bit            pend [2];
        logic [CB-1:0] cnt [2];
        logic [CB-1:0] ec;
        logic [1:0]    eg;
        int            w;

        tbl[0]  = '{2'b01, 31'd4096, 31'd0,    2'b01, 31'd4096, 1'b1, 4100, 1'b0};
        tbl[1]  = '{2'b11, 31'd16,   31'd32,   2'b10, 31'd32,   1'b1, 3,    1'b0};
        tbl[2]  = '{2'b11, 31'd16,   31'd32,   2'b01, 31'd16,   1'b1, 2,    1'b1};
        tbl[3]  = '{2'b11, 31'd16,   31'd32,   2'b10, 31'd32,   1'b1, 1,    1'b0};
        tbl[4]  = '{2'b11, 31'd16,   31'd32,   2'b01, 31'd16,   1'b1, 4,    1'b0};
        tbl[5]  = '{2'b10, 31'd0,    31'd5000, 2'b10, 31'd4096, 1'b1, 2,    1'b1};
        tbl[6]  = '{2'b01, 31'd0,    31'd9,    2'b01, 31'd0,    1'b0, 0,    1'b0};
        tbl[7]  = '{2'b01, 31'd7,    31'd9,    2'b01, 31'd7,    1'b1, 0,    1'b0};
        tbl[8]  = '{2'b11, 31'd1,    31'd4097, 2'b10, 31'd4096, 1'b1, 5,    1'b1};
        tbl[9]  = '{2'b10, 31'd3,    31'd0,    2'b10, 31'd0,    1'b0, 0,    1'b0};
        tbl[10] = '{2'b11, 31'd4095, 31'd2,    2'b01, 31'd4095, 1'b1, 1,    1'b0};

        reset     = 1'b1;
        i_req     = '0;
        i_num_cnt = '0;
        i_mv_idle = 1'b1;
        i_mv_done = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();
        chk("idle_busy", 64'(o_busy), 64'd0);

        foreach (tbl[i]) begin
            run_job(tbl[i].req, tbl[i].c0, tbl[i].c1, tbl[i].eg, tbl[i].ec,
                    tbl[i].er, tbl[i].dly, tbl[i].lvl, $sformatf("vec%0d", i));
        end

        // Mover busy for 20 cycles with a stale done level: nothing may launch.
        i_req     = 2'b01;
        i_num_cnt = {31'd0, 31'd9};
        i_mv_idle = 1'b0;
        i_mv_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("notidle_grant", 64'(o_grant), 64'd0);
            chk("notidle_busy",  64'(o_busy), 64'd0);
        end
        run_job(2'b01, 31'd9, 31'd0, 2'b01, 31'd9, 1'b1, 3, 1'b0, "notidle_job");

        // Reset in the middle of RUN; pointer must return to requester 0.
        i_req     = 2'b11;
        i_num_cnt = {31'd5, 31'd3};
        i_mv_idle = 1'b1;
        i_mv_done = 1'b0;
        tick();
        chk("rst_pre_grant", 64'(o_grant), 64'b10);
        i_mv_idle = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_reset_vals("rst_mid");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_wait_grant", 64'(o_grant), 64'd0);
        end
        run_job(2'b11, 31'd3, 31'd5, 2'b01, 31'd3, 1'b1, 2, 1'b0, "rst_regrant");

        // Randomized jobs against a transaction-level model of the requesters.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_mv_done = 1'b0;
        rr = 0;
        for (int k = 0; k < 2; k++) begin
            pend[k] = ($urandom_range(0, 1) == 1);
            cnt[k]  = rnd_cnt();
        end
        if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;

        for (int j = 0; j < 60; j++) begin
            win = pend[rr] ? rr : 1 - rr;
            eg  = 2'b01 << win;
            ec  = (cnt[win] > 31'd4096) ? 31'd4096 : cnt[win];
            i_req     = {pend[1], pend[0]};
            i_num_cnt = {cnt[1], cnt[0]};
            i_mv_idle = 1'b0;
            w = $urandom_range(0, 3);
            for (int i = 0; i < w; i++) begin
                tick();
                chk("rnd_wait_grant", 64'(o_grant), 64'd0);
            end
            run_job({pend[1], pend[0]}, cnt[0], cnt[1], eg, ec, (cnt[win] != '0),
                    $urandom_range(0, 6), ($urandom_range(0, 1) == 1),
                    $sformatf("rnd%0d", j));
            rr = (win + 1) % 2;
            pend[win] = ($urandom_range(0, 1) == 1);
            if (pend[win]) cnt[win] = rnd_cnt();
            if (!pend[1 - win] && $urandom_range(0, 1) == 1) begin
                pend[1 - win] = 1'b1;
                cnt[1 - win]  = rnd_cnt();
            end
            if (!pend[0] && !pend[1]) begin
                pend[win] = 1'b1;
                cnt[win]  = rnd_cnt();
            end
        end

        chk("final_timeout", 64'(o_timeout), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_mover_sched.md
# bram_mover_sched

Round-robin job scheduler that shares one `data_mover_bram` instance between `NUM_REQ` requesters, such as the per-core controllers of the multi-core build.
- Accepts one move request per requester, each with its own element count.
- Launches the mover with an `i_run` pulse and the selected `i_num_cnt`.
- Waits for the mover's `o_done`, then returns a per-requester completion pulse.
- Sits between the core-side control logic and the mover's `i_run`/`i_num_cnt`/`o_idle`/`o_done` pins.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `CNT_BIT`, 31: count width; matches the mover.
- `MEM_SIZE`, 4096: maximum legal count, equal to the BRAM depth.
- `TIMEOUT_CYC`, 65536: watchdog limit in cycles; used only with `MOVER_TIMEOUT_EN`.

Ports. Clock: `clk`, single clock. Reset: `reset`, synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  NUM_REQ  level request; bit k = requester k.
- `i_num_cnt`  in  NUM_REQ*CNT_BIT  packed counts; slice k = `[k*CNT_BIT +: CNT_BIT]`.
- `o_grant`  out  NUM_REQ  one-hot; held high for the whole job.
- `o_job_done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `o_busy`  out  1  high in every state except IDLE.
- `o_mv_run`  out  1  one-cycle launch pulse; drives the mover's `i_run`.
- `o_mv_num_cnt`  out  CNT_BIT  latched count; drives the mover's `i_num_cnt`; held stable from launch until completion.
- `i_mv_idle`  in  1  mover `o_idle`.
- `i_mv_done`  in  1  mover `o_done`; may be a pulse or a level.
- `o_timeout`  out  1  sticky watchdog flag.

## Operation
States:
- **IDLE**: a launch is taken when `|i_req && i_mv_idle`.
  - Winner: the first set bit of `i_req` at or after round-robin pointer `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Latch the winner's one-hot grant and its count.
  - Count == 0 → go to DONE without launching the mover.
  - Otherwise → go to LAUNCH.
- **LAUNCH**: `o_mv_run`=1 for exactly this state (one cycle); → RUN.
- **RUN**: wait until `i_mv_done`=1; → DONE.
- **DONE**: `o_job_done[g]`=1 for one cycle; `rr_ptr` ← g+1 (wraps to 0); `o_grant` cleared on exit; → IDLE.

Arithmetic and sampling rules:
- Latched count is saturated: a value > `MEM_SIZE` becomes `MEM_SIZE`.
- `i_mv_done` is sampled only in RUN. If done is still high from a previous job in any other state, it is ignored.
- `i_req` bits of non-granted requesters are ignored during a job.
- If the winner still holds `i_req` after its DONE cycle, that is a new request.
- A requester must hold `i_req` and its count slice stable until it is granted.

## Timing
- Reset values: `o_grant`=0, `o_job_done`=0, `o_busy`=0, `o_mv_run`=0, `o_mv_num_cnt`=0, `o_timeout`=0, `rr_ptr`=0, state=IDLE.
- All outputs are registered.
- Launch timing: with the request and `i_mv_idle` sampled at edge N, `o_grant`, `o_busy` and `o_mv_run` go high after edge N.
  - `o_mv_run` falls after edge N+1.
- Completion timing: with `i_mv_done` sampled in RUN at edge M, `o_job_done` goes high after edge M+1 for one cycle.
  - `o_busy` and `o_grant` fall after edge M+2.
- Zero-count job: grant and `o_job_done` are both visible one cycle apart (edges N and N+1); `o_mv_run` never asserts.
- Back-to-back jobs: the next launch can be sampled at the edge following DONE, provided `i_mv_idle`=1. Minimum IDLE dwell is 1 cycle.
- Reset mid-job: the block returns to its reset values at the next edge. The mover is not reset by this block; no new launch occurs until `i_mv_idle`=1.

## Configuration
`MOVER_TIMEOUT_EN`
- Defined:
  - A cycle counter clears on entry to RUN and increments every cycle in RUN.
  - When it reaches `TIMEOUT_CYC` without done: set `o_timeout` (sticky until `reset`) and go to DONE, which issues the normal `o_job_done` pulse.
- Undefined:
  - There is no counter and `o_timeout` is tied to 0.
  - RUN waits indefinitely for done.

## Test plan
- **Single job:** `i_req`=2'b01, count0=4096, mover done after 4100 cycles → `o_mv_run` pulses once, `o_mv_num_cnt`=4096, `o_job_done`=2'b01 once, `o_busy` drops.
- **Contention and fairness:** `i_req`=2'b11 held continuously, counts 16/32 → grants alternate 01,10,01,10; `o_mv_num_cnt` alternates 16/32; no back-to-back grant to the same requester.
- **Zero and oversize counts:** a count0=0 job → `o_job_done[0]` with no `o_mv_run` pulse. A count1=5000 job → `o_mv_num_cnt`=4096.
- **Mover not idle:** `i_req`=01 while `i_mv_idle`=0 for 20 cycles → no grant until the cycle after idle rises; stale `i_mv_done`=1 held in IDLE is ignored.
- **Reset mid-RUN:** assert `reset` 1 cycle → all outputs 0 after the edge, `rr_ptr`=0. Once idle is high again, a pending request is re-granted normally.
- **Watchdog (`MOVER_TIMEOUT_EN`, `TIMEOUT_CYC`=100):** no done for 100 cycles → `o_timeout`=1, `o_job_done` pulse, return to IDLE. `o_timeout` stays 1 until reset.
